tx_buffer_fill: RTL
===================

# tx_buffer_fill

Upstream producer for the TX MAC path. Accepts one Ethernet frame at a time as a length request plus a 64-bit data stream, and writes it into the 512×64 TX frame buffer as a header qword followed by payload qwords. Commits the frame to the downstream MAC-side reader by advancing `commited_wr_addr` only after the whole frame is in memory. Checks free space against the reader's `commited_rd_addr`, so the reader never sees a partial frame.

## Interface
- `MAX_FRAME_BYTES`, 1520: largest accepted frame length; must satisfy 1 + ceil(MAX/8) ≤ 512.
- `clk`  in  1  clock
- `reset_n`  in  1  reset, asynchronous, active-low
- `frm_req`  in  1  frame request; held until `frm_ack`
- `frm_len`  in  16  frame length in bytes, sampled with `frm_ack`
- `frm_ack`  out  1  one-cycle pulse; request accepted
- `data_in`  in  64  payload qword, byte 0 in [7:0]
- `data_valid`  in  1  `data_in` valid
- `data_ready`  out  1  block accepts a beat when `data_valid & data_ready`
- `wr_en`  out  1  buffer write strobe
- `wr_addr`  out  9  buffer write address
- `wr_data`  out  64  buffer write data
- `commited_wr_addr`  out  10  free-running write pointer of committed frames
- `commited_rd_addr`  in  10  free-running read pointer released by the reader
- `frames_written`  out  32  committed frame count
- `frames_dropped`  out  32  rejected frame count

## Operation
- Pointers are 10 bits and wrap modulo 1024. The buffer index is `ptr[8:0]`.
- Occupancy is `occ = wr_ptr − commited_rd_addr` (10-bit). Free space is `free = 512 − occ`, computed at 11 bits.
- Payload qword count: `nq = frm_len[15:3] + (frm_len[2:0] != 0)`. Space needed: `need = nq + 1`.
- Header qword: [63:32] = zero-extended `frm_len`, [31:0] = 0.
- Payload qwords follow the header at consecutive addresses. Bytes past `frm_len` in the last qword are don't-care.
- States:
  - IDLE: `frm_req` → latch length, pulse `frm_ack`, go to CALC.
  - CALC: compute `nq` and `need`. If `frm_len == 0` → count a drop, go to IDLE. If `frm_len > MAX_FRAME_BYTES` → go to DROP. Otherwise → SPACE.
  - SPACE: wait until `free ≥ need`, then → HDR.
  - HDR: write the header at `wr_ptr`, increment `wr_ptr`, go to DATA.
  - DATA: `data_ready = 1`. Each accepted beat writes at `wr_ptr` and increments it. After `nq` beats → COMMIT.
  - COMMIT: `commited_wr_addr <= wr_ptr`, `frames_written++`, go to IDLE.
  - DROP: `data_ready = 1`. Consume `nq` beats with no writes, `frames_dropped++`, go to IDLE.
- `data_ready` is 0 outside DATA and DROP. Beats presented then are left pending, not lost.
- `wr_ptr` is internal. It is never committed mid-frame, and it always equals `commited_wr_addr` in IDLE.
- An increase of `commited_rd_addr` while in SPACE is honoured on the next evaluation. The pointer never decreases.
- Reset mid-frame: the partial frame is discarded and all pointers return to 0. The reader is reset in the same domain.

## Timing
- Reset values: `frm_ack` 0, `data_ready` 0, `wr_en` 0, `wr_addr` 0, `wr_data` 0, `commited_wr_addr` 0, both counters 0, state IDLE.
- Request latency: `frm_ack` is asserted the cycle after `frm_req` is seen in IDLE.
- Write port: `wr_en`, `wr_addr` and `wr_data` are registered. A beat accepted in cycle t is written in cycle t+1. The header is written the cycle after HDR is entered.
- Commit: `commited_wr_addr` updates in cycle t+2, where t is the last accepted beat. Memory is written before the pointer moves.
- Best-case throughput: 1 beat/cycle. Per-frame overhead is 4 cycles (ack, CALC, SPACE, HDR) plus COMMIT.
- SPACE exits the cycle after `free ≥ need` becomes true.
- `wr_data` holds its last value when `wr_en` = 0.

## Structure
- Shared package `tx_buf_pkg`:
  - `BUF_DEPTH=512`, `ADDR_W=9`, `PTR_W=10`.
  - Header field positions: `HDR_LEN_MSB=63`, `HDR_LEN_LSB=32`.
  - State encoding.
  - Function `len_to_qwords(len)`, shared with the MAC-side reader.
- No sub-module. A single FSM with a pointer/counter datapath.

## Test plan
- Empty buffer, 64-byte frame → header `{32'd64, 32'd0}` at addr 0; payload at 1..8; `commited_wr_addr` 0→9 two cycles after beat 8; `frames_written`=1.
- 61-byte frame → nq=8, 8 beats consumed, commit advances by 9.
- `wr_ptr`=500, `commited_rd_addr`=0, 100-byte frame (need 14, free 12) → stalls in SPACE with `data_ready`=0. Setting `commited_rd_addr`=2 → proceeds; commit to 514.
- `wr_ptr`=1020, 64-byte frame → `wr_addr` 508..511 then 0..4; commit to 5.
- `frm_len`=0 → ack, 0 beats consumed, no `wr_en`. `frm_len`=2000 → 250 beats consumed, no `wr_en`, `frames_dropped`=2, commit unchanged.
- `reset_n` low at DATA beat 3 → all outputs at reset values. A following 64-byte frame is written from addr 0.

Source files
------------

// File: rtl/tx_buf_pkg.sv
// Shared definitions for the TX frame buffer: geometry, header layout, FSM
// encoding and the byte-length to qword-count helper used by writer and reader.
package tx_buf_pkg;

    localparam int BUF_DEPTH   = 512;
    localparam int ADDR_W      = 9;
    localparam int PTR_W       = 10;
    localparam int DATA_W      = 64;
    localparam int HDR_LEN_MSB = 63;
    localparam int HDR_LEN_LSB = 32;
    // Wide enough for the qword count of a 65535-byte length (8192) plus one.
    localparam int QW_W        = 14;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CALC,
        ST_SPACE,
        ST_HDR,
        ST_DATA,
        ST_COMMIT,
        ST_DROP
    } tx_state_e;

    function automatic logic [QW_W-1:0] len_to_qwords(input logic [15:0] len);
        return {1'b0, len[15:3]} + {{(QW_W-1){1'b0}}, (len[2:0] != 3'd0)};
    endfunction

    function automatic logic [DATA_W-1:0] make_header(input logic [15:0] len);
        logic [DATA_W-1:0] hdr;
        hdr = '0;
        hdr[HDR_LEN_MSB:HDR_LEN_LSB] = {16'd0, len};
        return hdr;
    endfunction

endpackage

// File: rtl/tx_buffer_fill.sv
// Writes one Ethernet frame at a time into the TX frame buffer as a header
// qword plus payload qwords, and publishes it to the reader only once complete.
module tx_buffer_fill
    import tx_buf_pkg::*;
#(
    parameter int MAX_FRAME_BYTES = 1520
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              frm_req,
    input  logic [15:0]       frm_len,
    output logic              frm_ack,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [PTR_W-1:0]  commited_wr_addr,
    input  logic [PTR_W-1:0]  commited_rd_addr,
    output logic [31:0]       frames_written,
    output logic [31:0]       frames_dropped
);

    tx_state_e         state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [QW_W-1:0]   nq_q, nq_d;
    logic [QW_W-1:0]   need_q, need_d;
    logic [QW_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  cwr_q, cwr_d;
    logic              ack_q, ack_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [31:0]       written_q, written_d;
    logic [31:0]       dropped_q, dropped_d;

    logic [PTR_W-1:0]  occ;
    logic [PTR_W:0]    free_words;
    logic              space_ok;
    logic              beat_fire;
    logic              last_beat;

    // Occupancy is measured against our own uncommitted pointer so space
    // already claimed by the frame in flight is never handed out twice.
    assign occ        = wr_ptr_q - commited_rd_addr;
    assign free_words = (PTR_W+1)'(BUF_DEPTH) - {1'b0, occ};
    assign space_ok   = {{(QW_W-PTR_W-1){1'b0}}, free_words} >= need_q;
    assign data_ready = (state_q == ST_DATA) || (state_q == ST_DROP);
    assign beat_fire  = data_valid && data_ready;
    assign last_beat  = (beat_cnt_q == nq_q - QW_W'(1));

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        nq_d       = nq_q;
        need_d     = need_q;
        beat_cnt_d = beat_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        cwr_d      = cwr_q;
        ack_d      = 1'b0;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        written_d  = written_q;
        dropped_d  = dropped_q;

        unique case (state_q)
            ST_IDLE: begin
                if (frm_req) begin
                    ack_d   = 1'b1;
                    len_d   = frm_len;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                nq_d       = len_to_qwords(len_q);
                need_d     = len_to_qwords(len_q) + QW_W'(1);
                beat_cnt_d = '0;
                if (len_q == 16'd0) begin
                    dropped_d = dropped_q + 32'd1;
                    state_d   = ST_IDLE;
                end else if (len_q > 16'(MAX_FRAME_BYTES)) begin
                    state_d = ST_DROP;
                end else begin
                    state_d = ST_SPACE;
                end
            end
            ST_SPACE: begin
                if (space_ok) begin
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                wr_en_d   = 1'b1;
                wr_addr_d = wr_ptr_q[ADDR_W-1:0];
                wr_data_d = make_header(len_q);
                wr_ptr_d  = wr_ptr_q + PTR_W'(1);
                state_d   = ST_DATA;
            end
            ST_DATA: begin
                if (beat_fire) begin
                    wr_en_d    = 1'b1;
                    wr_addr_d  = wr_ptr_q[ADDR_W-1:0];
                    wr_data_d  = data_in;
                    wr_ptr_d   = wr_ptr_q + PTR_W'(1);
                    beat_cnt_d = beat_cnt_q + QW_W'(1);
                    if (last_beat) begin
                        state_d = ST_COMMIT;
                    end
                end
            end
            // The last payload write is strobed this cycle, so the pointer
            // becomes visible to the reader only after memory holds it.
            ST_COMMIT: begin
                cwr_d     = wr_ptr_q;
                written_d = written_q + 32'd1;
                state_d   = ST_IDLE;
            end
            ST_DROP: begin
                if (beat_fire) begin
                    beat_cnt_d = beat_cnt_q + QW_W'(1);
                    if (last_beat) begin
                        dropped_d = dropped_q + 32'd1;
                        state_d   = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            beat_cnt_q <= '0;
            wr_ptr_q   <= '0;
            cwr_q      <= '0;
            ack_q      <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            written_q  <= '0;
            dropped_q  <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            cwr_q      <= cwr_d;
            ack_q      <= ack_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            written_q  <= written_d;
            dropped_q  <= dropped_d;
        end
    end

    // Length bookkeeping is always rewritten before use, so it needs no reset.
    always_ff @(posedge clk) begin
        len_q  <= len_d;
        nq_q   <= nq_d;
        need_q <= need_d;
    end

    assign frm_ack          = ack_q;
    assign wr_en            = wr_en_q;
    assign wr_addr          = wr_addr_q;
    assign wr_data          = wr_data_q;
    assign commited_wr_addr = cwr_q;
    assign frames_written   = written_q;
    assign frames_dropped   = dropped_q;

endmodule
